alu_issue_stage: RTL and testbench

- ID/EX issue stage: decodes a 32-bit RV32I instruction into the 4-bit ALU operation code and the ALU operand pair, and registers them toward the ALU.
- Sits between register-file read and the ALU. Valid/ready on both sides, with a 2-entry skid buffer so the ALU side can stall without a combinational ready path back to decode.
- Also carries rd, write-enable and branch qualifiers for downstream stages.

---
 rtl/alu_issue_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX issue stage. Decodes an RV32I instruction into a 4-bit ALU operation
// code plus the SrcA/SrcB operand pair and registers the result toward the
// ALU. A main register drives the outputs and a skid register absorbs one
// extra entry, so in_ready is a pure flop with no combinational path from
// out_ready.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync pipeline flush)
//   in_valid / in_ready            : upstream handshake (in_ready registered)
//   in_instr, in_rs1_data, in_rs2_data : raw instruction and register values
//   out_valid / out_ready          : downstream handshake toward the ALU
//   out_op, out_src_a, out_src_b   : ALU operation code and operands
//   out_rd, out_reg_write          : destination register and its write enable
//   out_branch, out_br_invert      : conditional branch qualifiers
//   out_illegal                    : unsupported encoding (entry still flows)
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic [DATA_WIDTH-1:0]    out_src_a,
    output logic [DATA_WIDTH-1:0]    out_src_b,
    output logic [4:0]               out_rd,
    output logic                     out_reg_write,
    output logic                     out_branch,
    output logic                     out_br_invert,
    output logic                     out_illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND    = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR    = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB    = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR     = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD    = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ     = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL    = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_PASS_B = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT    = OPCODE_LENGTH'(4'b1110);

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
        logic [4:0]               rd;
        logic                     reg_write;
        logic                     branch;
        logic                     br_invert;
        logic                     illegal;
    } entry_t;

    entry_t dec;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic signed [31:0]    imm_i32, imm_s32, imm_u32;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u, shamt;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u32 = {in_instr[31:12], 12'b0};
    // Signed casts sign-extend if the operand width is ever wider than 32.
    assign imm_i   = DATA_WIDTH'(imm_i32);
    assign imm_s   = DATA_WIDTH'(imm_s32);
    assign imm_u   = DATA_WIDTH'(imm_u32);
    assign shamt   = DATA_WIDTH'(in_instr[24:20]);

    always_comb begin
        logic ill;
        ill = 1'b0;
        dec = '0;
        dec.rd = in_instr[11:7];
        case (opcode)
            7'b0110011: begin
                dec.src_a = in_rs1_data;
                dec.src_b = in_rs2_data;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec.op = OP_ADD;
                        else if (funct7 == 7'b0100000) dec.op = OP_SUB;
                        else                           ill = 1'b1;
                    end
                    3'b111:  dec.op = OP_AND;
                    3'b110:  dec.op = OP_OR;
                    3'b100:  dec.op = OP_XOR;
                    3'b010:  dec.op = OP_SLT;
                    3'b001: begin
                        if (funct7 == 7'b0000000) dec.op = OP_SLL;
                        else                      ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.src_a = in_rs1_data;
                dec.src_b = imm_i;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_ADD;
                    3'b010:  dec.op = OP_SLT;
                    3'b100:  dec.op = OP_XOR;
                    3'b110:  dec.op = OP_OR;
                    3'b111:  dec.op = OP_AND;
                    3'b001: begin
                        dec.op = OP_SLL;
                        dec.src_b = shamt;
                        if (funct7 != 7'b0000000) ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.op = OP_ADD;
                dec.src_a = in_rs1_data;
                dec.src_b = imm_i;
                dec.reg_write = 1'b1;
                if (funct3 != 3'b010) ill = 1'b1;
            end
            7'b0100011: begin
                dec.op = OP_ADD;
                dec.src_a = in_rs1_data;
                dec.src_b = imm_s;
                if (funct3 != 3'b010) ill = 1'b1;
            end
            7'b1100011: begin
                dec.src_a = in_rs1_data;
                dec.src_b = in_rs2_data;
                dec.branch = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_EQ;
                    3'b001: begin
                        dec.op = OP_EQ;
                        dec.br_invert = 1'b1;
                    end
                    3'b100:  dec.op = OP_SLT;
                    default: ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec.op = OP_PASS_B;
                dec.src_b = imm_u;
                dec.reg_write = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal entries carry only rd and the illegal flag downstream.
        if (ill) begin
            dec = '0;
            dec.rd = in_instr[11:7];
            dec.illegal = 1'b1;
        end
    end

    // Data presented during a flush cycle is dropped even if handshaked.
    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (drain) begin
            if (skid_vld_q) begin
                // Older skid entry advances; a concurrent accept refills skid.
                main_d     = skid_q;
                skid_vld_d = accept;
                if (accept) skid_d = dec;
            end else begin
                main_vld_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = dec;
            end else begin
                skid_vld_d = 1'b1;
                skid_d     = dec;
            end
        end
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_vld_q;
    assign out_op        = main_q.op;
    assign out_src_a     = main_q.src_a;
    assign out_src_b     = main_q.src_b;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;
    assign out_branch    = main_q.branch;
    assign out_br_invert = main_q.br_invert;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios with literal expected
// values plus randomized traffic checked against a queue-based reference.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_rs1_data, in_rs2_data;
    logic        in_ready, out_valid;
    logic [3:0]  out_op;
    logic [31:0] out_src_a, out_src_b;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_branch, out_br_invert, out_illegal;

    int total = 0;
    int bad   = 0;

    exp_t mq[$];
    bit   m_rdy = 1'b1;
    exp_t obs;

    assign obs = {out_op, out_src_a, out_src_b, out_rd, out_reg_write,
                  out_branch, out_br_invert, out_illegal};

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_src_a(out_src_a), .out_src_b(out_src_b), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_branch(out_branch),
        .out_br_invert(out_br_invert), .out_illegal(out_illegal)
    );

    // Reference decode written straight from the instruction table.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] immi;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = {{20{ins[31]}}, ins[31:20]};
        e = '0;
        e.ill = 1'b1;
        if (opc == 7'h33) begin
            e.a = a; e.b = b; e.rw = 1'b1; e.ill = 1'b0;
            if (f3 == 0 && f7 == 0)          e.op = 4'b0100;
            else if (f3 == 0 && f7 == 7'h20) e.op = 4'b0010;
            else if (f3 == 7)                e.op = 4'b0000;
            else if (f3 == 6)                e.op = 4'b0011;
            else if (f3 == 4)                e.op = 4'b0001;
            else if (f3 == 2)                e.op = 4'b1110;
            else if (f3 == 1 && f7 == 0)     e.op = 4'b1001;
            else                             e.ill = 1'b1;
        end else if (opc == 7'h13) begin
            e.a = a; e.b = immi; e.rw = 1'b1; e.ill = 1'b0;
            if (f3 == 0)                 e.op = 4'b0100;
            else if (f3 == 2)            e.op = 4'b1110;
            else if (f3 == 4)            e.op = 4'b0001;
            else if (f3 == 6)            e.op = 4'b0011;
            else if (f3 == 7)            e.op = 4'b0000;
            else if (f3 == 1 && f7 == 0) begin e.op = 4'b1001; e.b = {27'd0, ins[24:20]}; end
            else                         e.ill = 1'b1;
        end else if (opc == 7'h03 && f3 == 2) begin
            e.op = 4'b0100; e.a = a; e.b = immi; e.rw = 1'b1; e.ill = 1'b0;
        end else if (opc == 7'h23 && f3 == 2) begin
            e.op = 4'b0100; e.a = a; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.ill = 1'b0;
        end else if (opc == 7'h63) begin
            e.a = a; e.b = b; e.br = 1'b1; e.ill = 1'b0;
            if (f3 == 0)      e.op = 4'b1000;
            else if (f3 == 1) begin e.op = 4'b1000; e.inv = 1'b1; end
            else if (f3 == 4) e.op = 4'b1110;
            else              e.ill = 1'b1;
        end else if (opc == 7'h37) begin
            e.op = 4'b1010; e.b = {ins[31:12], 12'd0}; e.rw = 1'b1; e.ill = 1'b0;
        end
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
        end
        e.rd = ins[11:7];
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // Called at a falling edge: apply inputs, advance the reference model
    // across the coming rising edge, and return at the next falling edge.
    task automatic drive_cycle(input bit vld, input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b, input bit ordy, input bit fl, input bit rst);
        bit drn, acc;
        in_valid = vld; in_instr = ins; in_rs1_data = a; in_rs2_data = b;
        out_ready = ordy; flush = fl; reset = rst;
        if (rst || fl) begin
            mq.delete();
            m_rdy = 1'b1;
        end else begin
            drn = (mq.size() > 0) && ordy;
            acc = vld && m_rdy;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(ins, a, b));
            m_rdy = (mq.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_cycle(1, 32'h002081B3, 32'h5, 32'h7, 0, 0, 1);
        drive_cycle(0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        total++;
        if (obs !== exp_t'(0)) begin bad++; $display("FAIL reset_data got=%h want=0", obs); end
        drive_cycle(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_directed_decode();
        exp_t want;
        drive_cycle(1, 32'h002081B3, 32'd5, 32'd7, 1, 0, 0);
        want = '{op:4'b0100, a:32'd5, b:32'd7, rd:5'd3, rw:1'b1, br:1'b0, inv:1'b0, ill:1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== want) begin bad++; $display("FAIL add v=%b got=%h want=%h", out_valid, obs, want); end

        drive_cycle(1, 32'hFFF00293, 32'd0, 32'h55, 1, 0, 0);
        want = '{op:4'b0100, a:32'd0, b:32'hFFFFFFFF, rd:5'd5, rw:1'b1, br:1'b0, inv:1'b0, ill:1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== want) begin bad++; $display("FAIL addi v=%b got=%h want=%h", out_valid, obs, want); end

        drive_cycle(1, 32'h123450B7, 32'hDEAD, 32'hBEEF, 1, 0, 0);
        want = '{op:4'b1010, a:32'd0, b:32'h12345000, rd:5'd1, rw:1'b1, br:1'b0, inv:1'b0, ill:1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== want) begin bad++; $display("FAIL lui v=%b got=%h want=%h", out_valid, obs, want); end

        drive_cycle(1, 32'h00209063, 32'd4, 32'd9, 1, 0, 0);
        want = '{op:4'b1000, a:32'd4, b:32'd9, rd:5'd0, rw:1'b0, br:1'b1, inv:1'b1, ill:1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== want) begin bad++; $display("FAIL bne v=%b got=%h want=%h", out_valid, obs, want); end

        drive_cycle(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] i1, i2, i3;
        i1 = 32'h00100093; i2 = 32'h00200113; i3 = 32'h00300193;
        drive_cycle(1, i1, 0, 0, 0, 0, 0);
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_first v=%b rd=%0d rdy=%b want 1/1/1", out_valid, out_rd, in_ready);
        end
        drive_cycle(1, i2, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b0 || out_rd !== 5'd1) begin
            bad++; $display("FAIL bp_second rdy=%b rd=%0d want 0/1", in_ready, out_rd);
        end
        drive_cycle(1, i3, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1 || out_src_b !== 32'd1) begin
            bad++; $display("FAIL bp_hold rdy=%b v=%b rd=%0d b=%0d want 0/1/1/1", in_ready, out_valid, out_rd, out_src_b);
        end
        drive_cycle(1, i3, 0, 0, 1, 0, 0);
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_src_b !== 32'd2 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_out2 v=%b rd=%0d b=%0d rdy=%b want 1/2/2/1", out_valid, out_rd, out_src_b, in_ready);
        end
        drive_cycle(1, i3, 0, 0, 1, 0, 0);
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_src_b !== 32'd3) begin
            bad++; $display("FAIL bp_out3 v=%b rd=%0d b=%0d want 1/3/3", out_valid, out_rd, out_src_b);
        end
        drive_cycle(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_empty v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        drive_cycle(1, 32'h00100093, 0, 0, 0, 0, 0);
        drive_cycle(1, 32'h00200113, 0, 0, 0, 0, 0);
        drive_cycle(1, 32'h00300193, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_clear v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(0, 0, 0, 0, 1, 0, 0);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cyc=%0d v=%b want 0", k, out_valid); end
        end
        drive_cycle(1, 32'h002081B3, 32'd11, 32'd22, 1, 0, 0);
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_src_a !== 32'd11) begin
            bad++; $display("FAIL flush_after v=%b rd=%0d a=%0d want 1/3/11", out_valid, out_rd, out_src_a);
        end
        drive_cycle(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_illegal_reset();
        exp_t want;
        drive_cycle(1, 32'h00000000, 32'h11, 32'h22, 0, 0, 0);
        want = '{op:4'b0000, a:32'd0, b:32'd0, rd:5'd0, rw:1'b0, br:1'b0, inv:1'b0, ill:1'b1};
        total++;
        if (out_valid !== 1'b1 || obs !== want) begin bad++; $display("FAIL illegal v=%b got=%h want=%h", out_valid, obs, want); end
        drive_cycle(1, 32'h00100093, 0, 0, 0, 0, 0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full rdy=%b want 0", in_ready); end
        drive_cycle(1, 32'h00200113, 0, 0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== exp_t'(0)) begin
            bad++; $display("FAIL reset_stall v=%b rdy=%b data=%h want 0/1/0", out_valid, in_ready, obs);
        end
        drive_cycle(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_stall_ghost v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        bit v, r, f, x;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 99) < 3);
            x = ($urandom_range(0, 199) == 0);
            drive_cycle(v, rand_instr(), $urandom, $urandom, r, f, x);
            total++;
            if (out_valid !== (mq.size() != 0)) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, out_valid, mq.size() != 0);
            end
            total++;
            if (in_ready !== m_rdy) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", n, in_ready, m_rdy);
            end
            if (mq.size() != 0) begin
                total++;
                if (obs !== mq[0]) begin
                    bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, obs, mq[0]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        @(negedge clk);
        test_reset();
        test_directed_decode();
        test_backpressure();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
